// File: rtl/b_mem_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// b_mem_pkg : shared types and helpers for the b_mem responder
// Rev 1.0
// ---------------------------------------------------------------------------
package b_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Wait-state counter width; never narrower than one bit so latency=0 still elaborates
    function automatic int cnt_width(input int lat);
        return (lat < 1) ? 1 : $clog2(lat + 1);
    endfunction

    localparam int DEFAULT_CNT_W = cnt_width(2);

endpackage
`default_nettype wire

// File: rtl/b_mem_array.sv
`default_nettype none
// ---------------------------------------------------------------------------
// b_mem_array : word array with synchronous write and asynchronous read
// Rev 1.0
// ---------------------------------------------------------------------------
module b_mem_array #(
    parameter int addrSize = 8,
    parameter int width    = 32
) (
    input  logic                clk,
    input  logic                we,
    input  logic [addrSize-1:0] addr,
    input  logic [width-1:0]    wdata,
    output logic [width-1:0]    rdata
);

    logic [width-1:0] mem [0:(1<<addrSize)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Sampled by the responder on the access edge, so this is the pre-write value
    assign rdata = mem[addr];

endmodule
`default_nettype wire

// File: rtl/b_mem_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// b_mem_responder : single-outstanding valid/ready memory target with wait states
// Rev 1.0
// ---------------------------------------------------------------------------
module b_mem_responder
    import b_mem_pkg::*;
#(
    parameter int addrSize = 8,
    parameter int width    = 32,
    parameter int latency  = 2
) (
    input  logic                clk,
    input  logic                Rnot,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [addrSize-1:0] req_addr,
    input  logic [width-1:0]    req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_we,
    output logic [width-1:0]    rsp_rdata
);

    localparam int             CNT_W    = cnt_width(latency);
    localparam logic [CNT_W-1:0] CNT_LOAD = (latency > 0) ? CNT_W'(latency - 1) : '0;

    state_t              state;
    state_t              state_next;
    logic [CNT_W-1:0]    cnt;
    logic [addrSize-1:0] cap_addr;
    logic                cap_we;
    logic [width-1:0]    cap_wdata;

    logic                do_access;
    logic                acc_we;
    logic [addrSize-1:0] acc_addr;
    logic [width-1:0]    acc_wdata;
    logic                mem_we;
    logic [width-1:0]    mem_rdata;

    // With zero wait states the access uses the live request on the acceptance edge
    always_comb begin
        state_next = state;
        do_access  = 1'b0;
        acc_addr   = cap_addr;
        acc_we     = cap_we;
        acc_wdata  = cap_wdata;
        case (state)
            IDLE: begin
                acc_addr  = req_addr;
                acc_we    = req_we;
                acc_wdata = req_wdata;
                if (req_valid) begin
                    if (latency == 0) begin
                        do_access  = 1'b1;
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    do_access  = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign mem_we    = do_access & acc_we;
    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    always_ff @(posedge clk or negedge Rnot) begin
        if (!Rnot) begin
            state     <= IDLE;
            cnt       <= '0;
            cap_addr  <= '0;
            cap_we    <= 1'b0;
            cap_wdata <= '0;
            rsp_we    <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && req_valid) begin
                cap_addr  <= req_addr;
                cap_we    <= req_we;
                cap_wdata <= req_wdata;
                cnt       <= CNT_LOAD;
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (do_access) begin
                rsp_we    <= acc_we;
                rsp_rdata <= acc_we ? acc_wdata : mem_rdata;
            end
        end
    end

    b_mem_array #(
        .addrSize (addrSize),
        .width    (width)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .addr  (acc_addr),
        .wdata (acc_wdata),
        .rdata (mem_rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_b_mem_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_b_mem_responder : directed bench for latency=2 and latency=0 builds
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_b_mem_responder;

    localparam int AW = 8;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // index 0: latency=2 build, index 1: latency=0 build
    logic          rnot      [2];
    logic          req_valid [2];
    logic          req_we    [2];
    logic [AW-1:0] req_addr  [2];
    logic [DW-1:0] req_wdata [2];
    logic          rsp_ready [2];

    logic          req_ready_a, rsp_valid_a, rsp_we_a;
    logic [DW-1:0] rsp_rdata_a;
    logic          req_ready_b, rsp_valid_b, rsp_we_b;
    logic [DW-1:0] rsp_rdata_b;

    b_mem_responder #(.addrSize(AW), .width(DW), .latency(2)) u_lat2 (
        .clk(clk), .Rnot(rnot[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready_a), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready[0]), .rsp_we(rsp_we_a),
        .rsp_rdata(rsp_rdata_a)
    );

    b_mem_responder #(.addrSize(AW), .width(DW), .latency(0)) u_lat0 (
        .clk(clk), .Rnot(rnot[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready_b), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready[1]), .rsp_we(rsp_we_b),
        .rsp_rdata(rsp_rdata_b)
    );

    int     n_checks = 0;
    int     n_fail   = 0;
    longint last_t [2];

    function automatic int lat(input int d);
        return (d == 0) ? 2 : 0;
    endfunction
    function automatic logic rdy(input int d);
        return (d == 0) ? req_ready_a : req_ready_b;
    endfunction
    function automatic logic rv(input int d);
        return (d == 0) ? rsp_valid_a : rsp_valid_b;
    endfunction
    function automatic logic rwe(input int d);
        return (d == 0) ? rsp_we_a : rsp_we_b;
    endfunction
    function automatic logic [DW-1:0] rdat(input int d);
        return (d == 0) ? rsp_rdata_a : rsp_rdata_b;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Issue one request, check latency/response, and complete the handshake if rsp_ready is high
    task automatic txn(input int d, input bit we, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input logic [DW-1:0] exp,
                       input bit chk_period, input string nm);
        int n;
        chk($sformatf("%s req_ready idle", nm), 64'(rdy(d)), 64'd1);
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        @(posedge clk);
        if (chk_period && last_t[d] >= 0)
            chk($sformatf("%s period", nm), 64'($time - last_t[d]), 64'((lat(d) + 2) * 10));
        last_t[d] = $time;
        #1;
        req_valid[d] = 1'b0;
        req_we[d]    = 1'b0;
        n = 0;
        while (!rv(d) && n < 20) begin
            chk($sformatf("%s req_ready wait", nm), 64'(rdy(d)), 64'd0);
            @(posedge clk);
            #1;
            n++;
        end
        chk($sformatf("%s latency", nm), 64'(n), 64'(lat(d)));
        chk($sformatf("%s rsp_we", nm), 64'(rwe(d)), 64'(we));
        chk($sformatf("%s rsp_rdata", nm), 64'(rdat(d)), 64'(exp));
        chk($sformatf("%s req_ready resp", nm), 64'(rdy(d)), 64'd0);
        if (rsp_ready[d]) begin
            @(posedge clk);
            #1;
            chk($sformatf("%s rsp_valid drop", nm), 64'(rv(d)), 64'd0);
        end
    endtask

    typedef struct {
        int            d;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vecs [19];

    initial begin
        logic [DW-1:0] held;
        for (int i = 0; i < 2; i++) begin
            rnot[i] = 1'b0; req_valid[i] = 1'b0; req_we[i] = 1'b0;
            req_addr[i] = '0; req_wdata[i] = '0; rsp_ready[i] = 1'b1;
            last_t[i] = -1;
        end

        vecs[0]  = '{0, 1'b1, 8'h10, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[1]  = '{0, 1'b0, 8'h10, 32'h0,        32'hDEADBEEF};
        vecs[2]  = '{0, 1'b1, 8'h11, 32'h00000001, 32'h00000001};
        vecs[3]  = '{0, 1'b0, 8'h11, 32'h0,        32'h00000001};
        vecs[4]  = '{0, 1'b0, 8'h10, 32'h0,        32'hDEADBEEF};
        vecs[5]  = '{0, 1'b1, 8'h00, 32'h11111111, 32'h11111111};
        vecs[6]  = '{0, 1'b1, 8'hFF, 32'hA5A55A5A, 32'hA5A55A5A};
        vecs[7]  = '{0, 1'b0, 8'hFF, 32'h0,        32'hA5A55A5A};
        vecs[8]  = '{0, 1'b0, 8'h00, 32'h0,        32'h11111111};
        vecs[9]  = '{0, 1'b0, 8'h10, 32'h0,        32'hDEADBEEF};
        vecs[10] = '{1, 1'b1, 8'h00, 32'h0,        32'h0};
        vecs[11] = '{1, 1'b1, 8'h01, 32'h1,        32'h1};
        vecs[12] = '{1, 1'b1, 8'h02, 32'h2,        32'h2};
        vecs[13] = '{1, 1'b1, 8'h03, 32'h3,        32'h3};
        vecs[14] = '{1, 1'b0, 8'h00, 32'h0,        32'h0};
        vecs[15] = '{1, 1'b0, 8'h01, 32'h0,        32'h1};
        vecs[16] = '{1, 1'b0, 8'h02, 32'h0,        32'h2};
        vecs[17] = '{1, 1'b0, 8'h03, 32'h0,        32'h3};
        vecs[18] = '{1, 1'b0, 8'h01, 32'h0,        32'h1};

        #2;
        chk("reset req_ready", 64'(req_ready_a), 64'd1);
        chk("reset rsp_valid", 64'(rsp_valid_a), 64'd0);
        chk("reset rsp_we",    64'(rsp_we_a),    64'd0);
        chk("reset rsp_rdata", 64'(rsp_rdata_a), 64'd0);
        chk("reset lat0 req_ready", 64'(req_ready_b), 64'd1);
        chk("reset lat0 rsp_valid", 64'(rsp_valid_b), 64'd0);
        @(posedge clk); #1;
        rnot[0] = 1'b1; rnot[1] = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 19; i++)
            txn(vecs[i].d, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp,
                1'b1, $sformatf("vec%0d", i));

        // Backpressure: response held for five cycles, a competing request must be ignored
        rsp_ready[0] = 1'b0;
        txn(0, 1'b0, 8'h10, 32'h0, 32'hDEADBEEF, 1'b0, "bp read");
        held = rsp_rdata_a;
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 8'h10; req_wdata[0] = 32'h0BAD0BAD;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("bp rsp_valid held", 64'(rsp_valid_a), 64'd1);
            chk("bp rsp_rdata stable", 64'(rsp_rdata_a), 64'(held));
            chk("bp req_ready low", 64'(req_ready_a), 64'd0);
        end
        req_valid[0] = 1'b0; req_we[0] = 1'b0;
        rsp_ready[0] = 1'b1;
        @(posedge clk); #1;
        chk("bp release rsp_valid", 64'(rsp_valid_a), 64'd0);
        chk("bp release req_ready", 64'(req_ready_a), 64'd1);
        txn(0, 1'b0, 8'h10, 32'h0, 32'hDEADBEEF, 1'b0, "bp no write");

        // Reset in the middle of WAIT must drop the pending write
        txn(0, 1'b1, 8'h20, 32'h12345678, 32'h12345678, 1'b0, "preload");
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 8'h20; req_wdata[0] = 32'hCAFEF00D;
        @(posedge clk); #1;
        req_valid[0] = 1'b0; req_we[0] = 1'b0;
        chk("rst pre req_ready", 64'(req_ready_a), 64'd0);
        #2;
        rnot[0] = 1'b0;
        #1;
        chk("rst req_ready", 64'(req_ready_a), 64'd1);
        chk("rst rsp_valid", 64'(rsp_valid_a), 64'd0);
        chk("rst rsp_we",    64'(rsp_we_a),    64'd0);
        chk("rst rsp_rdata", 64'(rsp_rdata_a), 64'd0);
        @(posedge clk); #1;
        rnot[0] = 1'b1;
        txn(0, 1'b0, 8'h20, 32'h0, 32'h12345678, 1'b0, "rst no write");

        // Latency-0 read after write at the top address
        txn(1, 1'b1, 8'hFF, 32'h5EEDF00D, 32'h5EEDF00D, 1'b0, "lat0 wr ff");
        txn(1, 1'b0, 8'hFF, 32'h0, 32'h5EEDF00D, 1'b0, "lat0 rd ff");
        txn(1, 1'b0, 8'h00, 32'h0, 32'h0, 1'b0, "lat0 rd 00");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
